// File: rtl/ram_8x16_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 8x16 RAM.
// One transaction in flight: IDLE samples requests, ACCESS drives the RAM, DONE pulses ack.
module ram_8x16_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] dados_in_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] dados_out_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] dados_in_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] dados_out_b,
  output logic              ram_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dados_in,
  input  logic [DATA_W-1:0] ram_dados_out,
  output logic              busy,
  output logic              grant_b
);

  // state  | meaning
  // IDLE   | sample requests, latch the winner's fields
  // ACCESS | RAM enabled for one cycle; write or read completes at its end
  // DONE   | ack pulse to the winner, then back to IDLE
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   lat_we;
  logic   win_b;
  logic   start;

  always_comb begin
    state_nxt        = state;
    start            = 1'b0;
    // Tie goes to whoever did not win last time.
    win_b            = (req_a && req_b) ? ~last_grant : req_b;
    ram_enable       = 1'b0;
    ram_write_enable = 1'b0;
    busy             = 1'b0;
    ack_a            = 1'b0;
    ack_b            = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ram_enable       = 1'b1;
        ram_write_enable = lat_we;
        busy             = 1'b1;
        state_nxt        = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        ack_a     = ~grant_b;
        ack_b     = grant_b;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_b      <= 1'b0;
      lat_we       <= 1'b0;
      ram_addr     <= '0;
      ram_dados_in <= '0;
      dados_out_a  <= '0;
      dados_out_b  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        last_grant   <= win_b;
        grant_b      <= win_b;
        lat_we       <= win_b ? we_b : we_a;
        ram_addr     <= win_b ? addr_b : addr_a;
        ram_dados_in <= win_b ? dados_in_b : dados_in_a;
      end
      if (state == ACCESS && !lat_we) begin
        if (grant_b) dados_out_b <= ram_dados_out;
        else         dados_out_a <= ram_dados_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_8x16_arbiter.sv
// Directed bench for ram_8x16_arbiter with a behavioural 8x16 RAM attached.
module tb_ram_8x16_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] dados_in_a, dados_in_b;
  logic        ack_a, ack_b;
  logic [15:0] dados_out_a, dados_out_b;
  logic        ram_enable, ram_write_enable;
  logic [2:0]  ram_addr;
  logic [15:0] ram_dados_in;
  wire  [15:0] ram_dados_out;
  logic        busy, grant_b;

  logic [15:0] mem [8];
  int checks = 0;
  int errors = 0;

  ram_8x16_arbiter #(.ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .dados_in_a(dados_in_a),
    .ack_a(ack_a), .dados_out_a(dados_out_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .dados_in_b(dados_in_b),
    .ack_b(ack_b), .dados_out_b(dados_out_b),
    .ram_enable(ram_enable), .ram_write_enable(ram_write_enable),
    .ram_addr(ram_addr), .ram_dados_in(ram_dados_in),
    .ram_dados_out(ram_dados_out),
    .busy(busy), .grant_b(grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_enable && ram_write_enable) mem[ram_addr] <= ram_dados_in;

  assign ram_dados_out = (ram_enable && !ram_write_enable) ? mem[ram_addr] : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Full single-requester transaction; ack is checked in the DONE cycle.
  task automatic run_txn(input logic b, input logic we, input logic [2:0] addr,
                         input logic [15:0] data);
    if (b) begin req_b = 1'b1; we_b = we; addr_b = addr; dados_in_b = data; end
    else   begin req_a = 1'b1; we_a = we; addr_a = addr; dados_in_a = data; end
    tick();
    check("txn_ram_addr", 32'(ram_addr), 32'(addr));
    check("txn_grant", 32'(grant_b), 32'(b));
    tick();
    check("txn_ack", {30'd0, ack_b, ack_a}, b ? 32'd2 : 32'd1);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    req_a = 0; we_a = 0; addr_a = 0; dados_in_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; dados_in_b = 0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_acks", {30'd0, ack_b, ack_a}, 32'd0);
    check("rst_dout_a", 32'(dados_out_a), 32'd0);
    check("rst_dout_b", 32'(dados_out_b), 32'd0);
    check("rst_ram_en", {30'd0, ram_enable, ram_write_enable}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", 32'(ram_dados_in), 32'd0);
    check("rst_busy", {30'd0, busy, grant_b}, 32'd0);
    reset = 1'b0;

    // A writes BEEF to 5, then reads it back
    req_a = 1; we_a = 1; addr_a = 3'd5; dados_in_a = 16'hBEEF;
    tick();
    check("wr_ram_en", 32'(ram_enable), 32'd1);
    check("wr_ram_we", 32'(ram_write_enable), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'd5);
    check("wr_ram_din", 32'(ram_dados_in), 32'hBEEF);
    check("wr_busy_acc", 32'(busy), 32'd1);
    check("wr_ack_early", 32'(ack_a), 32'd0);
    tick();
    check("wr_ack_a", 32'(ack_a), 32'd1);
    check("wr_ram_en_done", 32'(ram_enable), 32'd0);
    check("wr_addr_hold", 32'(ram_addr), 32'd5);
    req_a = 0;
    tick();
    check("wr_idle", {30'd0, busy, ack_a}, 32'd0);
    req_a = 1; we_a = 0; addr_a = 3'd5;
    tick();
    check("rd_ram_we", {30'd0, ram_enable, ram_write_enable}, 32'd2);
    tick();
    check("rd_ack_a", 32'(ack_a), 32'd1);
    check("rd_dout_a", 32'(dados_out_a), 32'hBEEF);
    req_a = 0;
    tick();

    // simultaneous writes after reset: A first, B three cycles later
    do_reset();
    req_a = 1; we_a = 1; addr_a = 3'd2; dados_in_a = 16'h1111;
    req_b = 1; we_b = 1; addr_b = 3'd3; dados_in_b = 16'h2222;
    tick();
    check("sim_grant_a", 32'(grant_b), 32'd0);
    tick();
    check("sim_ack_a", {30'd0, ack_b, ack_a}, 32'd1);
    req_a = 0;
    tick();
    check("sim_gap1", {30'd0, ack_b, ack_a}, 32'd0);
    tick();
    check("sim_grant_b", 32'(grant_b), 32'd1);
    check("sim_addr_b", 32'(ram_addr), 32'd3);
    tick();
    check("sim_ack_b", {30'd0, ack_b, ack_a}, 32'd2);
    req_b = 0;
    tick();
    run_txn(1'b0, 1'b0, 3'd2, 16'h0);
    check("sim_rd2", 32'(dados_out_a), 32'h1111);
    run_txn(1'b1, 1'b0, 3'd3, 16'h0);
    check("sim_rd3", 32'(dados_out_b), 32'h2222);

    // continuous contention: A,B,A,B,A,B
    do_reset();
    req_a = 1; we_a = 1; addr_a = 3'd4; dados_in_a = 16'h4444;
    req_b = 1; we_b = 1; addr_b = 3'd6; dados_in_b = 16'h6666;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_grant", 32'(grant_b), 32'(i % 2));
      tick();
      check("rr_ack", {30'd0, ack_b, ack_a}, (i % 2) ? 32'd2 : 32'd1);
      if (i % 2) req_b = 0; else req_a = 0;
      tick();
      check("rr_no_overlap", 32'(ack_a & ack_b), 32'd0);
      req_a = 1;
      req_b = 1;
    end
    req_a = 0;
    req_b = 0;

    // B read of 7 with addr_b changed during ACCESS
    run_txn(1'b1, 1'b1, 3'd7, 16'h00FF);
    run_txn(1'b0, 1'b0, 3'd2, 16'h0);
    check("mid_dout_a_pre", 32'(dados_out_a), 32'h1111);
    req_b = 1; we_b = 0; addr_b = 3'd7;
    tick();
    addr_b = 3'd0;
    we_b = 1;
    check("mid_ram_addr", 32'(ram_addr), 32'd7);
    tick();
    check("mid_ack_b", 32'(ack_b), 32'd1);
    check("mid_dout_b", 32'(dados_out_b), 32'h00FF);
    check("mid_dout_a", 32'(dados_out_a), 32'h1111);
    req_b = 0;
    tick();

    // reset in the middle of an A write
    req_a = 1; we_a = 1; addr_a = 3'd1; dados_in_a = 16'hAAAA;
    tick();
    check("rw_en_before", 32'(ram_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rw_en_async", 32'(ram_enable), 32'd0);
    check("rw_busy_async", 32'(busy), 32'd0);
    req_a = 0;
    tick();
    check("rw_no_ack", {30'd0, ack_b, ack_a}, 32'd0);
    tick();
    reset = 1'b0;
    check("rw_busy_rel", 32'(busy), 32'd0);
    check("rw_ack_rel", 32'(ack_a), 32'd0);
    req_a = 1; we_a = 0; addr_a = 3'd2;
    req_b = 1; we_b = 0; addr_b = 3'd3;
    tick();
    check("rw_first_grant", 32'(grant_b), 32'd0);
    req_a = 0;
    req_b = 0;
    tick();
    check("rw_ack_a", {30'd0, ack_b, ack_a}, 32'd1);
    tick();

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", {28'd0, ram_enable, busy, ack_a, ack_b}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
